// File: rtl/break_join_pkg.sv
// Shared types and helpers for the break/join path between buffer_fifo and the UART.
// The break (word -> bytes) and future join (bytes -> word) controllers both import this.
package break_join_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } brk_state_t;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_BYTE_SIZE = 8;

  function automatic int num_bytes(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  // A single-slice word still needs a one-bit index so the counter never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_break_ctrl.sv
// Read-side controller for buffer_fifo: pops one word and streams it to the UART TX
// as BYTE_SIZE slices, least-significant slice first, over a valid/ready handshake.
module fifo_word_break_ctrl
  import break_join_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 fifo_r_enable,
  output logic [BYTE_SIZE-1:0] byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 word_done,
  output logic                 busy
);

  localparam int NUM_BYTES = num_bytes(WORD_SIZE, BYTE_SIZE);
  localparam int IDX_W     = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  brk_state_t           state;
  brk_state_t           state_next;
  logic [WORD_SIZE-1:0] word_reg;
  logic [WORD_SIZE-1:0] word_next;
  logic [IDX_W-1:0]     byte_idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 pop;
  logic                 xfer;
  logic                 last_slice;
  logic                 can_pop;

  assign xfer       = (state == SEND) && byte_ready;
  assign last_slice = (byte_idx == LAST_IDX);
  // Reset also masks the pop strobe so the FIFO never loses a word while we are held in reset.
  assign can_pop    = enable && !fifo_empty && !reset;

  assign fifo_r_enable = pop;
  assign byte_valid    = (state == SEND);
  assign busy          = (state == SEND);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_reg <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_next;
      word_reg <= word_next;
      byte_idx <= idx_next;
    end
  end

  // A reload on the last-slice handshake keeps SEND asserted, giving back-to-back words with no bubble.
  always_comb begin
    state_next = state;
    word_next  = word_reg;
    idx_next   = byte_idx;
    pop        = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop        = 1'b1;
          word_next  = fifo_data;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_slice) begin
            word_done = 1'b1;
            if (can_pop) begin
              pop       = 1'b1;
              word_next = fifo_data;
              idx_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = byte_idx + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        byte_out = word_reg[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_break_ctrl.sv
// Directed bench for fifo_word_break_ctrl: a queue-based show-ahead FIFO feeds the 32/8 instance
// and a slice scoreboard checks every handshake; a second 16/8 instance covers the narrow variant.
module tb_fifo_word_break_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_r_enable;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        word_done;
  logic        busy;

  logic        b_enable;
  logic        b_empty;
  logic [15:0] b_data;
  logic        b_r_enable;
  logic [7:0]  b_byte_out;
  logic        b_byte_valid;
  logic        b_ready;
  logic        b_word_done;
  logic        b_busy;

  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];
  logic        m_busy;
  int          pop_count;
  int          test_count;
  int          fail_count;
  int          p0;

  fifo_word_break_ctrl #(.WORD_SIZE(32), .BYTE_SIZE(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_r_enable (fifo_r_enable),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .word_done     (word_done),
    .busy          (busy)
  );

  fifo_word_break_ctrl #(.WORD_SIZE(16), .BYTE_SIZE(8)) dut16 (
    .clock         (clock),
    .reset         (reset),
    .enable        (b_enable),
    .fifo_empty    (b_empty),
    .fifo_data     (b_data),
    .fifo_r_enable (b_r_enable),
    .byte_out      (b_byte_out),
    .byte_valid    (b_byte_valid),
    .byte_ready    (b_ready),
    .word_done     (b_word_done),
    .busy          (b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    test_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = w[i*8 +: 8];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
    refresh_fifo();
  endtask

  // One clock cycle, entered and left at a falling edge: drive, check mid-cycle, then let the edge act.
  task automatic apply_stimulus(input logic rdy, input logic en);
    logic xfer;
    logic last;
    logic exp_pop;
    logic do_pop;
    byte_ready = rdy;
    enable     = en;
    #1;
    xfer    = m_busy && rdy;
    last    = xfer && (exp_q.size() != 0) && exp_q[0].last;
    exp_pop = !reset && en && (fifo_q.size() != 0) && (!m_busy || last);
    check_output("byte_valid", 32'(byte_valid), 32'(m_busy));
    check_output("busy", 32'(busy), 32'(m_busy));
    check_output("fifo_r_enable", 32'(fifo_r_enable), 32'(exp_pop));
    check_output("word_done", 32'(word_done), 32'(last));
    if (m_busy) begin
      if (exp_q.size() == 0) begin
        check_output("scoreboard_underrun", 32'(byte_valid), 32'(0));
      end else begin
        check_output("byte_out", 32'(byte_out), 32'(exp_q[0].data));
      end
    end
    if (xfer && exp_q.size() != 0) exp_q.delete(0);
    do_pop = fifo_r_enable && (fifo_q.size() != 0);
    @(posedge clock);
    if (exp_pop) m_busy = 1'b1;
    else if (last) m_busy = 1'b0;
    #1;
    if (do_pop) begin
      fifo_q.delete(0);
      pop_count++;
      refresh_fifo();
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_busy || fifo_q.size() != 0); i++) begin
      apply_stimulus(1'b1, 1'b1);
    end
    apply_stimulus(1'b1, 1'b1);
    check_output("drain_idle", 32'(busy), 32'(0));
    check_output("scoreboard_left", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    pop_count  = 0;
    m_busy     = 1'b0;
    reset      = 1'b1;
    enable     = 1'b1;
    byte_ready = 1'b0;
    b_enable   = 1'b1;
    b_empty    = 1'b1;
    b_data     = 16'h0;
    b_ready    = 1'b0;
    refresh_fifo();

    // Reset state of both instances
    #2;
    check_output("rst_byte_valid", 32'(byte_valid), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_fifo_r_enable", 32'(fifo_r_enable), 32'(0));
    check_output("rst_word_done", 32'(word_done), 32'(0));
    check_output("rst_byte_out", 32'(byte_out), 32'(0));
    check_output("rst16_byte_valid", 32'(b_byte_valid), 32'(0));
    check_output("rst16_busy", 32'(b_busy), 32'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single word");
    p0 = pop_count;
    push_word(32'hA1B2C3D4);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b1);
    check_output("single_pop_count", 32'(pop_count - p0), 32'(1));

    $display("[TB] backpressure");
    p0 = pop_count;
    push_word(32'hA1B2C3D4);
    apply_stimulus(1'b1, 1'b1);
    begin
      logic [6:0] pattern;
      pattern = 7'b1001011;
      for (int i = 6; i >= 0; i--) apply_stimulus(pattern[i], 1'b1);
    end
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    check_output("bp_pop_count", 32'(pop_count - p0), 32'(1));
    check_output("bp_scoreboard_left", 32'(exp_q.size()), 32'(0));

    $display("[TB] back-to-back");
    p0 = pop_count;
    push_word(32'h11223344);
    push_word(32'h55667788);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b1);
    check_output("b2b_pop_count", 32'(pop_count - p0), 32'(2));
    check_output("b2b_scoreboard_left", 32'(exp_q.size()), 32'(0));

    $display("[TB] enable gating");
    push_word(32'hCAFEF00D);
    push_word(32'h01234567);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0);
    check_output("gate_fifo_level", 32'(fifo_q.size()), 32'(2));
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
    check_output("gate_fifo_kept", 32'(fifo_q.size()), 32'(1));
    check_output("gate_idle", 32'(busy), 32'(0));
    drain();

    $display("[TB] async reset mid-word");
    push_word(32'hDEADBEEF);
    push_word(32'h0BADF00D);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_byte_valid", 32'(byte_valid), 32'(0));
    check_output("arst_busy", 32'(busy), 32'(0));
    check_output("arst_fifo_r_enable", 32'(fifo_r_enable), 32'(0));
    check_output("arst_byte_out", 32'(byte_out), 32'(0));
    if (m_busy) begin
      while (exp_q.size() != 0 && !exp_q[0].last) exp_q.delete(0);
      if (exp_q.size() != 0) exp_q.delete(0);
    end
    m_busy = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    drain();

    $display("[TB] 16/8 variant");
    b_data  = 16'hBEEF;
    b_empty = 1'b0;
    b_ready = 1'b1;
    #1;
    check_output("w16_pop", 32'(b_r_enable), 32'(1));
    check_output("w16_idle_valid", 32'(b_byte_valid), 32'(0));
    @(posedge clock);
    #1;
    b_empty = 1'b1;
    b_data  = 16'h0;
    @(negedge clock);
    #1;
    check_output("w16_valid0", 32'(b_byte_valid), 32'(1));
    check_output("w16_slice0", 32'(b_byte_out), 32'h0EF);
    check_output("w16_done0", 32'(b_word_done), 32'(0));
    check_output("w16_no_repop", 32'(b_r_enable), 32'(0));
    @(negedge clock);
    #1;
    check_output("w16_slice1", 32'(b_byte_out), 32'h0BE);
    check_output("w16_done1", 32'(b_word_done), 32'(1));
    @(negedge clock);
    #1;
    check_output("w16_end_valid", 32'(b_byte_valid), 32'(0));
    check_output("w16_end_busy", 32'(b_busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
